// File: rtl/systolic_array_pkg.sv
// Shared types and constants for the systolic-array tile scheduler.
package systolic_array_pkg;

  // Default watchdog limit (cycles in any single wait state) and its counter width.
  localparam int TSCHED_TMO   = 255;
  localparam int TSCHED_TMO_W = $clog2(TSCHED_TMO + 1);

  typedef enum logic [3:0] {
    TS_IDLE,
    TS_ISSUE,
    TS_WAIT_LD_HI,
    TS_WAIT_LD_LO,
    TS_WAIT_SA_HI,
    TS_WAIT_SA_LO,
    TS_DRAIN,
    TS_NEXT,
    TS_DONE
  } tsched_state_t;

  // True for the four states in which the watchdog runs.
  function automatic logic tsched_is_wait(tsched_state_t s);
    return (s == TS_WAIT_LD_HI) || (s == TS_WAIT_LD_LO) ||
           (s == TS_WAIT_SA_HI) || (s == TS_WAIT_SA_LO);
  endfunction

endpackage

// File: rtl/matmul_tile_sched_if.sv
// Host command channel of the tile scheduler.
//
// Handshake: a command transfers on a rising clock edge where cmd_valid_i and
// cmd_ready_o are both high. The host holds every cmd_* field stable while
// cmd_valid_i is high; the scheduler never stalls a transfer once ready is up,
// and while ready is low valid is ignored (no queueing).
interface matmul_tile_sched_if #(
  parameter int N  = 4,
  parameter int AW = 6
);
  localparam int CW = $clog2(N + 1);

  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_x_base_i;
  logic [AW-1:0] cmd_w_base_i;
  logic [AW-1:0] cmd_y_base_i;
  logic [CW-1:0] cmd_rows_i;
  logic [CW-1:0] cmd_cols_i;

  modport master (
    output cmd_valid_i, cmd_x_base_i, cmd_w_base_i, cmd_y_base_i,
           cmd_rows_i, cmd_cols_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i, cmd_x_base_i, cmd_w_base_i, cmd_y_base_i,
           cmd_rows_i, cmd_cols_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/tsched_wdog.sv
// Watchdog for the scheduler wait states: a down-counter reloaded on clear and
// decremented while enabled. expired is high in the TMO-th enabled cycle
// after a clear.
module tsched_wdog
  import systolic_array_pkg::*;
#(
  parameter int TMO = TSCHED_TMO,
  parameter int TW  = TSCHED_TMO_W
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TW-1:0] LOAD = TW'(TMO - 1);

  logic [TW-1:0] cnt_q;

  // Reload on clear, count down while enabled, saturate at zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= LOAD;
    end else if (clear) begin
      cnt_q <= LOAD;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  // Does not look at clear, so the FSM can feed clear from its next state.
  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/matmul_tile_sched.sv
// Tile scheduler: walks a rows x cols tile grid, starting the loader for each
// tile, waiting for load and compute, then draining the N result lanes into
// the Y scratchpad.
module matmul_tile_sched
  import systolic_array_pkg::*;
#(
  parameter int N   = 4,
  parameter int AW  = 6,
  parameter int DW  = 32,
  parameter int TMO = TSCHED_TMO
) (
  input  logic                   clk,
  input  logic                   n_rst,
  matmul_tile_sched_if.slave     cmd,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   ld_start_o,
  output logic [AW-1:0]          ld_base_x_o,
  output logic [AW-1:0]          ld_base_w_o,
  input  logic                   ld_busy_i,
  input  logic                   sa_stall_i,
  output logic [$clog2(N)-1:0]   y_index_o,
  input  logic [DW-1:0]          y_data_i,
  output logic                   y_csb0_o,
  output logic [AW-1:0]          y_addr0_o,
  output logic [DW-1:0]          y_din0_o,
  output tsched_state_t          dbg_state_o
);

  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TMO + 1);
  localparam logic [IW-1:0] K_LAST = IW'(N - 1);
  localparam logic [CW:0]   C_ONE  = (CW+1)'(1);

  tsched_state_t state_q, state_d;
  logic [AW-1:0] x_base_q, x_base_d, w_base_q, w_base_d, y_base_q, y_base_d;
  logic [CW-1:0] rows_q, rows_d, cols_q, cols_d, r_q, r_d, c_q, c_d;
  logic [IW-1:0] k_q, k_d;
  logic          err_q, err_d;
  logic          wd_expired;
  logic [AW-1:0] ld_x_nxt, ld_w_nxt, y_wr_addr;

  // Loader bases for the tile about to be issued; Y address for the lane being drained.
  assign ld_x_nxt  = x_base_d + AW'(32'(r_d) * N);
  assign ld_w_nxt  = w_base_d + AW'(c_d);
  assign y_wr_addr = y_base_q
                   + AW'((32'(r_q) * 32'(cols_q) + 32'(c_q)) * N + 32'(k_q));

  tsched_wdog #(.TMO(TMO), .TW(TW)) u_wdog (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (state_d != state_q),
    .enable  (tsched_is_wait(state_q)),
    .expired (wd_expired)
  );

  // Next-state, tile-position and error logic.
  always_comb begin
    state_d  = state_q;
    x_base_d = x_base_q;
    w_base_d = w_base_q;
    y_base_d = y_base_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    r_d      = r_q;
    c_d      = c_q;
    k_d      = '0;
    err_d    = err_q;
    case (state_q)
      TS_IDLE: begin
        // cmd_ready_o is high exactly while in IDLE.
        if (cmd.cmd_valid_i) begin
          x_base_d = cmd.cmd_x_base_i;
          w_base_d = cmd.cmd_w_base_i;
          y_base_d = cmd.cmd_y_base_i;
          rows_d   = cmd.cmd_rows_i;
          cols_d   = cmd.cmd_cols_i;
          r_d      = '0;
          c_d      = '0;
          err_d    = 1'b0;
          state_d  = ((cmd.cmd_rows_i == '0) || (cmd.cmd_cols_i == '0)) ? TS_DONE : TS_ISSUE;
        end
      end
      TS_ISSUE: state_d = TS_WAIT_LD_HI;
      TS_WAIT_LD_HI, TS_WAIT_LD_LO, TS_WAIT_SA_HI, TS_WAIT_SA_LO: begin
        // A stuck handshake abandons the remaining tiles.
        if (wd_expired) begin
          err_d   = 1'b1;
          state_d = TS_DONE;
        end else if ((state_q == TS_WAIT_LD_HI) && ld_busy_i) begin
          state_d = TS_WAIT_LD_LO;
        end else if ((state_q == TS_WAIT_LD_LO) && !ld_busy_i) begin
          state_d = TS_WAIT_SA_HI;
        end else if ((state_q == TS_WAIT_SA_HI) && sa_stall_i) begin
          state_d = TS_WAIT_SA_LO;
        end else if ((state_q == TS_WAIT_SA_LO) && !sa_stall_i) begin
          state_d = TS_DRAIN;
        end
      end
      TS_DRAIN: begin
        if (k_q == K_LAST) state_d = TS_NEXT;
        else               k_d     = k_q + IW'(1);
      end
      TS_NEXT: begin
        if (({1'b0, c_q} + C_ONE) < {1'b0, cols_q}) begin
          c_d     = c_q + CW'(1);
          state_d = TS_ISSUE;
        end else if (({1'b0, r_q} + C_ONE) < {1'b0, rows_q}) begin
          r_d     = r_q + CW'(1);
          c_d     = '0;
          state_d = TS_ISSUE;
        end else begin
          state_d = TS_DONE;
        end
      end
      TS_DONE: state_d = TS_IDLE;
      default: state_d = TS_IDLE;
    endcase
  end

  // Command, position and FSM state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= TS_IDLE;
      x_base_q <= '0;
      w_base_q <= '0;
      y_base_q <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      r_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_base_q <= x_base_d;
      w_base_q <= w_base_d;
      y_base_q <= y_base_d;
      rows_q   <= rows_d;
      cols_q   <= cols_d;
      r_q      <= r_d;
      c_q      <= c_d;
      k_q      <= k_d;
      err_q    <= err_d;
    end
  end

  // Registered outputs: status and loader controls track the next state,
  // the Y write lands one cycle after its DRAIN lane was selected.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cmd.cmd_ready_o <= 1'b1;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      ld_start_o      <= 1'b0;
      ld_base_x_o     <= '0;
      ld_base_w_o     <= '0;
      y_csb0_o        <= 1'b1;
      y_addr0_o       <= '0;
      y_din0_o        <= '0;
    end else begin
      cmd.cmd_ready_o <= (state_d == TS_IDLE);
      busy_o          <= (state_d != TS_IDLE) && (state_d != TS_DONE);
      done_o          <= (state_d == TS_DONE);
      ld_start_o      <= (state_d == TS_ISSUE);
      if (state_d == TS_ISSUE) begin
        ld_base_x_o <= ld_x_nxt;
        ld_base_w_o <= ld_w_nxt;
      end
      y_csb0_o <= (state_q != TS_DRAIN);
      if (state_q == TS_DRAIN) begin
        y_addr0_o <= y_wr_addr;
        y_din0_o  <= y_data_i;
      end
    end
  end

  assign err_o       = err_q;
  assign y_index_o   = k_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_matmul_tile_sched.sv
// Bench for matmul_tile_sched: behavioural loader/array, scoreboard queues
// filled from a grid-walk reference model, monitor comparing DUT activity.
`timescale 1ns/1ps
module tb_matmul_tile_sched;
  import systolic_array_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int TMO = 40;
  localparam int CW  = $clog2(N + 1);
  localparam int IW  = $clog2(N);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  matmul_tile_sched_if #(.N(N), .AW(AW)) cmd_if ();

  logic          busy_o, done_o, err_o, ld_start_o, ld_busy_i, sa_stall_i;
  logic [AW-1:0] ld_base_x_o, ld_base_w_o, y_addr0_o;
  logic [IW-1:0] y_index_o;
  logic [DW-1:0] y_data_i, y_din0_o;
  logic          y_csb0_o;
  tsched_state_t dbg_state_o;

  matmul_tile_sched #(.N(N), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .n_rst(n_rst), .cmd(cmd_if),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .ld_start_o(ld_start_o), .ld_base_x_o(ld_base_x_o), .ld_base_w_o(ld_base_w_o),
    .ld_busy_i(ld_busy_i), .sa_stall_i(sa_stall_i),
    .y_index_o(y_index_o), .y_data_i(y_data_i),
    .y_csb0_o(y_csb0_o), .y_addr0_o(y_addr0_o), .y_din0_o(y_din0_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  logic [2*AW-1:0]  exp_ld_q[$];    // {x_base, w_base}
  logic [AW+DW-1:0] exp_wr_q[$];    // {addr, data}
  logic [15:0]      exp_done_q[$];  // {latency, kind, err}; kind 1=from accept, 2=from last start
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, accept_cyc = 0, last_start_cyc = 0, done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural loader / array ----------------
  bit            ld_dead = 0, ld_fixed = 0;
  logic [DW-1:0] cur_salt = '0;
  int            arr_tile = 0, starts = 0, ld_cnt = 0, sa_cnt = 0;

  // Lane k of tile t returns salt + 16*t + k.
  always_comb y_data_i = cur_salt + DW'(arr_tile * 16) + DW'(y_index_o);

  initial begin
    ld_busy_i  = 1'b0;
    sa_stall_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        ld_busy_i = 1'b0; sa_stall_i = 1'b0; ld_cnt = 0; sa_cnt = 0;
      end else begin
        if (cmd_if.cmd_valid_i && cmd_if.cmd_ready_o) starts = 0;
        if (ld_start_o) begin
          arr_tile = starts;
          starts++;
          if (!ld_dead) begin
            ld_cnt    = ld_fixed ? 20 : $urandom_range(20, 2);
            ld_busy_i = 1'b1;
          end
        end else if (ld_cnt > 0) begin
          ld_cnt--;
          if (ld_cnt == 0) begin
            ld_busy_i  = 1'b0;
            sa_cnt     = ld_fixed ? 8 : $urandom_range(8, 2);
            sa_stall_i = 1'b1;
          end
        end else if (sa_cnt > 0) begin
          sa_cnt--;
          if (sa_cnt == 0) sa_stall_i = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [15:0] d;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        cyc++;
        if (cmd_if.cmd_valid_i && cmd_if.cmd_ready_o) accept_cyc = cyc;
        if (ld_start_o) begin
          last_start_cyc = cyc;
          check("ld_start_expected", exp_ld_q.size() != 0, 1);
          if (exp_ld_q.size() != 0) check("ld_bases", {ld_base_x_o, ld_base_w_o}, exp_ld_q.pop_front());
        end
        if (!y_csb0_o) begin
          check("y_write_expected", exp_wr_q.size() != 0, 1);
          if (exp_wr_q.size() != 0) check("y_write", {y_addr0_o, y_din0_o}, exp_wr_q.pop_front());
        end
        if (done_o) begin
          check("done_expected", exp_done_q.size() != 0, 1);
          if (exp_done_q.size() != 0) begin
            d = exp_done_q.pop_front();
            check("done_err", err_o, d[0]);
            check("done_busy_low", busy_o, 0);
            if (d[2:1] == 2'd1) check("done_lat_accept", cyc - accept_cyc, d[15:3]);
            if (d[2:1] == 2'd2) check("done_lat_start", cyc - last_start_cyc, d[15:3]);
            check("done_ld_left", exp_ld_q.size(), 0);
            check("done_wr_left", exp_wr_q.size(), 0);
          end
          done_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Reference model: walk the grid row-major and list what the DUT must do.
  task automatic push_expect(input logic [AW-1:0] xb, wb, yb, input int rows, cols,
                             input logic [DW-1:0] salt, input bit dead);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (!dead || (r == 0 && c == 0))
          exp_ld_q.push_back({AW'(int'(xb) + r * N), AW'(int'(wb) + c)});
        if (!dead)
          for (int k = 0; k < N; k++)
            exp_wr_q.push_back({AW'(int'(yb) + (r * cols + c) * N + k),
                                salt + DW'((r * cols + c) * 16 + k)});
      end
    end
    if (rows == 0 || cols == 0) exp_done_q.push_back({13'd1, 2'd1, 1'b0});
    else if (dead)              exp_done_q.push_back({13'(TMO + 1), 2'd2, 1'b1});
    else                        exp_done_q.push_back({13'd0, 2'd0, 1'b0});
  endtask

  task automatic issue_cmd(input logic [AW-1:0] xb, wb, yb, input int rows, cols,
                           input logic [DW-1:0] salt, input bit dead, input bit fixed);
    int w;
    ld_dead = dead; ld_fixed = fixed; cur_salt = salt;
    w = 0;
    @(posedge clk); #1;
    while (!cmd_if.cmd_ready_o && w < 200) begin @(posedge clk); #1; w++; end
    check("ready_before_cmd", cmd_if.cmd_ready_o, 1);
    cmd_if.cmd_x_base_i = xb;  cmd_if.cmd_w_base_i = wb;  cmd_if.cmd_y_base_i = yb;
    cmd_if.cmd_rows_i = CW'(rows);  cmd_if.cmd_cols_i = CW'(cols);
    cmd_if.cmd_valid_i = 1'b1;
    @(posedge clk); #1;
    check("err_clear_on_accept", err_o, 0);
    check("busy_after_accept", busy_o, (rows > 0 && cols > 0));
    if (rows > 0 && cols > 0) begin
      // Commands offered while busy must be ignored.
      for (int i = 0; i < 3; i++) begin
        cmd_if.cmd_x_base_i = AW'($urandom); cmd_if.cmd_w_base_i = AW'($urandom);
        cmd_if.cmd_y_base_i = AW'($urandom);
        cmd_if.cmd_rows_i = CW'($urandom_range(N, 0)); cmd_if.cmd_cols_i = CW'($urandom_range(N, 0));
        @(posedge clk); #1;
      end
    end
    cmd_if.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt);
    int w;
    w = 0;
    while (done_cnt == start_cnt && w < 3000) begin @(negedge clk); w++; end
    check("done_seen", done_cnt != start_cnt, 1);
    @(negedge clk);
  endtask

  task automatic run_cmd(input logic [AW-1:0] xb, wb, yb, input int rows, cols,
                         input logic [DW-1:0] salt, input bit dead, input bit fixed);
    int sc;
    sc = done_cnt;
    push_expect(xb, wb, yb, rows, cols, salt, dead);
    issue_cmd(xb, wb, yb, rows, cols, salt, dead, fixed);
    wait_done(sc);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_if.cmd_ready_o, 1);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_ld_start"}, ld_start_o, 0);
    check({tag, "_ld_bases"}, {ld_base_x_o, ld_base_w_o}, 0);
    check({tag, "_y_index"}, y_index_o, 0);
    check({tag, "_y_csb0"}, y_csb0_o, 1);
    check({tag, "_y_addr_din"}, {y_addr0_o, y_din0_o}, 0);
    check({tag, "_state"}, dbg_state_o, TS_IDLE);
  endtask

  task automatic reset_mid_drain();
    int w;
    push_expect(6'd8, 6'd20, 6'd40, 1, 2, 32'h55, 1'b0);
    issue_cmd(6'd8, 6'd20, 6'd40, 1, 2, 32'h55, 1'b0, 1'b0);
    w = 0;
    @(negedge clk);
    while (!(dbg_state_o == TS_DRAIN && y_index_o == IW'(2)) && w < 3000) begin @(negedge clk); w++; end
    check("reached_drain_k2", (dbg_state_o == TS_DRAIN) && (y_index_o == IW'(2)), 1);
    #2 n_rst = 1'b0;
    #1 check_reset_values("mid_rst");
    exp_ld_q.delete(); exp_wr_q.delete(); exp_done_q.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("after_rst_ready", cmd_if.cmd_ready_o, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cmd_if.cmd_valid_i = 1'b0;
    cmd_if.cmd_x_base_i = '0; cmd_if.cmd_w_base_i = '0; cmd_if.cmd_y_base_i = '0;
    cmd_if.cmd_rows_i = '0;   cmd_if.cmd_cols_i = '0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    n_rst = 1'b1;

    run_cmd(6'd0, 6'd16, 6'd32, 1, 1, 32'd100, 1'b0, 1'b1);   // single tile
    run_cmd(6'd0, 6'd16, 6'd32, 4, 4, $urandom, 1'b0, 1'b0);  // full grid
    run_cmd(6'd5, 6'd9,  6'd3,  0, 3, $urandom, 1'b0, 1'b0);  // empty grid
    run_cmd(6'd0, 6'd0,  6'd62, 1, 1, $urandom, 1'b0, 1'b0);  // Y address wrap
    run_cmd(6'd7, 6'd11, 6'd13, 2, 2, $urandom, 1'b1, 1'b0);  // watchdog
    repeat (3) @(negedge clk);
    check("err_sticky_idle", err_o, 1);
    run_cmd(6'd60, 6'd62, 6'd50, 2, 3, $urandom, 1'b0, 1'b0); // clears err
    reset_mid_drain();
    run_cmd(6'd1, 6'd2, 6'd3, 3, 2, $urandom, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++)
      run_cmd(AW'($urandom), AW'($urandom), AW'($urandom),
              $urandom_range(N, 0), $urandom_range(N, 0), $urandom, 1'b0, 1'b0);

    check("final_ld_q_empty", exp_ld_q.size(), 0);
    check("final_wr_q_empty", exp_wr_q.size(), 0);
    check("final_done_q_empty", exp_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #600000;
    $display("FAIL global_timeout: simulation still running at t=%0t, limit 600000", $time);
    $fatal(1, "timeout");
  end

endmodule
